pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Hazard and pipeline-sequencing unit for the 5-stage MIPS-subset CPU. It watches the instruction in IF/ID and the destination registers in flight in ID/EX and EX/MEM, and generates `stall_b` for the instruction controller. It also drives the PC/IF-ID write enables, the pipeline flushes for redirects, a global freeze while data memory is busy, and the halt drain sequence.

## Interface
- `DRAIN_CYCLES`, 4: cycles to retire the instructions older than `halt` before `halted` asserts (1..15).
- `clk` input 1: clock, rising edge.
- `rst_b` input 1: asynchronous active-low reset.
- `if_id_instruction` input 32: instruction currently in ID.
- `id_ex_mem_read` input 1: instruction in EX is `lw`.
- `id_ex_reg_write` input 1: instruction in EX writes a register.
- `id_ex_dst` input 5: final destination register of EX instruction.
- `ex_mem_reg_write` input 1: instruction in MEM writes a register.
- `ex_mem_dst` input 5: destination register of MEM instruction.
- `pc_redirect` input 1: taken `beq` or `j` resolved in EX.
- `mem_busy` input 1: data memory not ready.
- `stall_b` output 1: 0 means the controller emits NOP controls into ID/EX.
- `pc_write` output 1: PC update enable.
- `if_id_write` output 1: IF/ID load enable.
- `if_id_flush` output 1: zero IF/ID.
- `id_ex_flush` output 1: zero ID/EX.
- `pipe_en` output 1: enable for ID/EX, EX/MEM and MEM/WB registers.
- `halted` output 1: core halted.
- `stall_cycles` output 16: saturating count of hazard-stall cycles.

## Operation
- Source use in ID: `rs` [25:21] is read by every opcode except 0x02 (`j`) and 0x3f (`halt`). `rt` [20:16] is read by 0x00 (R-type), 0x04 (`beq`) and 0x2b (`sw`). Register 0 never causes a hazard.
- Load-use hazard: `id_ex_mem_read && id_ex_dst!=0 && id_ex_dst` matches a used source.
- The FSM has three states: RUN, DRAIN, HALTED. Outputs are a Mealy function of the state and the current inputs.
- Priority in RUN, highest first:
  1. `mem_busy`: `pipe_en=0`, `pc_write=0`, `if_id_write=0`, `stall_b=1`, no flush.
  2. `pc_redirect`: `if_id_flush=1`, `id_ex_flush=1`, `pc_write=1`.
  3. Data hazard: `stall_b=0`, `pc_write=0`, `if_id_write=0`; `stall_cycles` increments.
  4. Opcode 0x3f in ID: `stall_b=0`, `pc_write=0`, `if_id_write=0`; load the drain counter with `DRAIN_CYCLES`; go to DRAIN.
  5. Otherwise: all enables 1, flushes 0, `stall_b=1`.
- DRAIN:
  - `pc_write=0`, `if_id_write=0`, `stall_b=0`.
  - The counter decrements only in cycles where `pipe_en=1`; `mem_busy` freezes the pipe and the counter.
  - `pc_redirect` in DRAIN means the halt was on a wrong path: flush both registers, `pc_write=1`, return to RUN.
  - When the counter reaches 0, go to HALTED.
- HALTED: `halted=1`, `pipe_en=0`, `pc_write=0`, `if_id_write=0`, `stall_b=0`. Only reset leaves this state.
- `stall_cycles` saturates at 0xFFFF.

## Timing
- While `rst_b`=0: state RUN, drain counter 0, `stall_cycles=0`, `halted=0`, `stall_b=0`, `pc_write=0`, `if_id_write=0`, `pipe_en=0`, both flushes 0. Normal RUN outputs apply from the first cycle after deassertion.
- Hazard, redirect and freeze responses appear combinationally in the same cycle the inputs are valid. State, counters and `halted` update on the `clk` edge.
- A load-use stall lasts exactly 1 cycle with forwarding; the `lw` advances out of EX, so the condition clears.
- Simultaneous `mem_busy` and `pc_redirect`: the freeze wins. The redirect is honoured in the first cycle `mem_busy` is low, because the EX contents are held.
- Halt latency is (number of `pipe_en` cycles) `DRAIN_CYCLES`+1 edges from halt in ID to `halted=1`.
- Asserting reset at any point, including mid-drain, returns to RUN immediately.

## Configuration
- `SEQ_FORWARDING_EN` defined: the datapath has a forwarding unit, so only load-use hazards stall.
- Not defined: any used-source match against `id_ex_dst` (with `id_ex_reg_write`) or `ex_mem_dst` (with `ex_mem_reg_write`), nonzero, also stalls. Stall persists until the producer leaves MEM, and `stall_cycles` counts every such cycle.

## Test plan
- Reset then `add $3,$1,$2` in ID with no in-flight writes: `stall_b=1`, `pc_write=1`, `stall_cycles=0`.
- EX `lw` to $5, `mem_read=1`; ID `add $6,$5,$1`: exactly 1 cycle of `stall_b=0`, `pc_write=0`; `stall_cycles=1`. Same with `$0` as destination: no stall.
- Without `SEQ_FORWARDING_EN`: MEM writes $4, ID `sw $4,0($1)`: stall 1 cycle. EX writes $4 instead: stall 2 cycles.
- `pc_redirect=1` together with `mem_busy=1` for 3 cycles: no flush and `pipe_en=0` for 3 cycles, then a single cycle with both flushes 1.
- `halt` (0x3f) in ID, `DRAIN_CYCLES=4`, `mem_busy` pulsed 2 cycles during drain: `halted` rises 7 edges later. `pc_redirect` during drain instead: back to RUN, `halted` stays 0.
- Force 70000 consecutive load-use hazards: `stall_cycles` holds at 0xFFFF; `rst_b` low mid-count clears it to 0 asynchronously.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Hazard/sequencing unit for the 5-stage MIPS-subset pipeline: stalls, flushes, memory freeze, halt drain.
// Build option: define SEQ_FORWARDING_EN when the datapath forwards, so only load-use hazards stall.
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] if_id_instruction,
  input  logic        id_ex_mem_read,
  input  logic        id_ex_reg_write,
  input  logic [4:0]  id_ex_dst,
  input  logic        ex_mem_reg_write,
  input  logic [4:0]  ex_mem_dst,
  input  logic        pc_redirect,
  input  logic        mem_busy,
  output logic        stall_b,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        pipe_en,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] drain_cnt, drain_nxt;
  logic       stall_inc;

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       uses_rs, uses_rt, is_halt;
  logic       ex_match, mem_match, load_use, hazard;
  logic       unused_bits;

  assign opcode  = if_id_instruction[31:26];
  assign rs      = if_id_instruction[25:21];
  assign rt      = if_id_instruction[20:16];
  assign uses_rs = (opcode != 6'h02) && (opcode != 6'h3f);
  assign uses_rt = (opcode == 6'h00) || (opcode == 6'h04) || (opcode == 6'h2b);
  assign is_halt = (opcode == 6'h3f);

  // $0 is hardwired, so a zero destination can never create a dependency
  assign ex_match  = (id_ex_dst != 5'd0) &&
                     ((uses_rs && rs == id_ex_dst) || (uses_rt && rt == id_ex_dst));
  assign mem_match = (ex_mem_dst != 5'd0) &&
                     ((uses_rs && rs == ex_mem_dst) || (uses_rt && rt == ex_mem_dst));
  assign load_use  = id_ex_mem_read && ex_match;

`ifdef SEQ_FORWARDING_EN
  assign hazard = load_use;
`else
  assign hazard = load_use || (id_ex_reg_write && ex_match) || (ex_mem_reg_write && mem_match);
`endif

  assign unused_bits = ^{if_id_instruction[15:0], id_ex_reg_write, ex_mem_reg_write, ex_mem_dst};
  assign halted      = (state == HALTED);

  always_comb begin
    state_nxt   = state;
    drain_nxt   = drain_cnt;
    stall_inc   = 1'b0;
    stall_b     = 1'b0;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_en     = 1'b0;
    if (rst_b) begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            stall_b = 1'b1;
          end else if (pc_redirect) begin
            stall_b     = 1'b1;
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pipe_en     = 1'b1;
          end else if (hazard) begin
            pipe_en   = 1'b1;
            stall_inc = 1'b1;
          end else if (is_halt) begin
            pipe_en   = 1'b1;
            drain_nxt = DRAIN_LOAD;
            state_nxt = DRAIN;
          end else begin
            stall_b     = 1'b1;
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            pipe_en     = 1'b1;
          end
        end
        DRAIN: begin
          // A redirect while draining means the halt itself was fetched down a wrong path
          if (!mem_busy) begin
            if (pc_redirect) begin
              stall_b     = 1'b1;
              pc_write    = 1'b1;
              if_id_write = 1'b1;
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
              pipe_en     = 1'b1;
              drain_nxt   = 4'd0;
              state_nxt   = RUN;
            end else begin
              pipe_en = 1'b1;
              if (drain_cnt <= 4'd1) begin
                drain_nxt = 4'd0;
                state_nxt = HALTED;
              end else begin
                drain_nxt = drain_cnt - 4'd1;
              end
            end
          end
        end
        HALTED: begin
          state_nxt = HALTED;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= RUN;
      drain_cnt    <= 4'd0;
      stall_cycles <= 16'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (stall_inc && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus randomized traffic vs a priority-rule model.
// Honours SEQ_FORWARDING_EN the same way the design does.
module tb_pipeline_sequencer;

  localparam int DRAIN = 4;
`ifdef SEQ_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_b;
  logic [31:0] if_id_instruction;
  logic        id_ex_mem_read, id_ex_reg_write, ex_mem_reg_write;
  logic [4:0]  id_ex_dst, ex_mem_dst;
  logic        pc_redirect, mem_busy;
  logic        stall_b, pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en, halted;
  logic [15:0] stall_cycles;
  logic [6:0]  obs;

  int checks = 0;
  int errors = 0;

  // Model state: 0 = running, 1 = draining, 2 = halted
  int m_state;
  int m_cnt;
  int m_stalls;

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst_b(rst_b), .if_id_instruction(if_id_instruction),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write), .id_ex_dst(id_ex_dst),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_dst(ex_mem_dst),
    .pc_redirect(pc_redirect), .mem_busy(mem_busy),
    .stall_b(stall_b), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .pipe_en(pipe_en),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  assign obs = {stall_b, pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit src_hit(input logic [31:0] ins, input logic [4:0] r);
    logic [5:0] op;
    bit hit;
    op  = ins[31:26];
    hit = 1'b0;
    if (r == 5'd0) return 1'b0;
    if (op != 6'h02 && op != 6'h3f && ins[25:21] == r) hit = 1'b1;
    if ((op == 6'h00 || op == 6'h04 || op == 6'h2b) && ins[20:16] == r) hit = 1'b1;
    return hit;
  endfunction

  function automatic bit m_hazard();
    bit lu, dep;
    lu  = id_ex_mem_read && src_hit(if_id_instruction, id_ex_dst);
    dep = (id_ex_reg_write && src_hit(if_id_instruction, id_ex_dst)) ||
          (ex_mem_reg_write && src_hit(if_id_instruction, ex_mem_dst));
    return FWD ? lu : (lu || dep);
  endfunction

  // Expected {stall_b, pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en, halted}
  function automatic logic [6:0] exp_out();
    if (!rst_b) return 7'b0000000;
    if (m_state == 2) return 7'b0000001;
    if (m_state == 1) begin
      if (mem_busy) return 7'b0000000;
      if (pc_redirect) return 7'b1111110;
      return 7'b0000010;
    end
    if (mem_busy) return 7'b1000000;
    if (pc_redirect) return 7'b1111110;
    if (m_hazard()) return 7'b0000010;
    if (if_id_instruction[31:26] == 6'h3f) return 7'b0000010;
    return 7'b1110010;
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_cnt    = 0;
    m_stalls = 0;
  endtask

  // Advance one clock edge, moving the model by the spec rules using the inputs present before the edge
  task automatic tick();
    int ns, nc, nst;
    ns = m_state; nc = m_cnt; nst = m_stalls;
    if (rst_b) begin
      if (m_state == 0 && !mem_busy && !pc_redirect) begin
        if (m_hazard()) nst = (m_stalls < 65535) ? m_stalls + 1 : 65535;
        else if (if_id_instruction[31:26] == 6'h3f) begin ns = 1; nc = DRAIN; end
      end else if (m_state == 1 && !mem_busy) begin
        if (pc_redirect) begin ns = 0; nc = 0; end
        else begin
          nc = m_cnt - 1;
          if (nc == 0) ns = 2;
        end
      end
    end
    @(posedge clk);
    m_state = ns; m_cnt = nc; m_stalls = nst;
    @(negedge clk);
  endtask

  task automatic set_idle();
    if_id_instruction = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    id_ex_mem_read = 0; id_ex_reg_write = 0; id_ex_dst = 0;
    ex_mem_reg_write = 0; ex_mem_dst = 0;
    pc_redirect = 0; mem_busy = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_b = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (obs !== 7'b0 || stall_cycles !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b/%0d expected 0000000/0", obs, stall_cycles);
    end
    @(negedge clk);
    rst_b = 1;
    #2;
    checks++;
    if (stall_b !== 1'b1 || pc_write !== 1'b1 || stall_cycles !== 16'd0 || obs !== exp_out()) begin
      errors++;
      $display("[TB] FAIL reset_first_add: got %b/%0d expected %b/0", obs, stall_cycles, exp_out());
    end
    tick();
  endtask

  task automatic test_load_use();
    int base;
    base = m_stalls;
    set_idle();
    id_ex_mem_read = 1; id_ex_reg_write = 1; id_ex_dst = 5;
    if_id_instruction = {6'h00, 5'd5, 5'd1, 5'd6, 5'd0, 6'h20};
    #2;
    checks++;
    if (stall_b !== 1'b0 || pc_write !== 1'b0 || if_id_write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_use_stall: got %b expected stall_b=0 pc_write=0", obs);
    end
    tick();
    id_ex_mem_read = 0; id_ex_reg_write = 0; id_ex_dst = 0;
    ex_mem_reg_write = 1; ex_mem_dst = 5;
    #2;
    checks++;
    if (obs !== exp_out() || stall_b !== FWD) begin
      errors++;
      $display("[TB] FAIL load_use_second: got %b expected %b", obs, exp_out());
    end
    tick();
    ex_mem_reg_write = 0; ex_mem_dst = 0;
    #2;
    checks++;
    if (stall_b !== 1'b1 || stall_cycles !== 16'(base + (FWD ? 1 : 2))) begin
      errors++;
      $display("[TB] FAIL load_use_count: got %b/%0d expected 1/%0d", stall_b, stall_cycles, base + (FWD ? 1 : 2));
    end
    tick();
    id_ex_mem_read = 1; id_ex_reg_write = 1; id_ex_dst = 0;
    if_id_instruction = {6'h00, 5'd0, 5'd1, 5'd6, 5'd0, 6'h20};
    #2;
    checks++;
    if (stall_b !== 1'b1 || pc_write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_use_r0: got %b expected stall_b=1 pc_write=1", obs);
    end
    tick();
  endtask

  task automatic test_dependency_stall();
    int base;
    set_idle();
    base = m_stalls;
    ex_mem_reg_write = 1; ex_mem_dst = 4;
    if_id_instruction = {6'h2b, 5'd1, 5'd4, 16'h0000};
    #2;
    checks++;
    if (stall_b !== FWD || obs !== exp_out()) begin
      errors++;
      $display("[TB] FAIL mem_dep_stall: got %b expected %b", obs, exp_out());
    end
    tick();
    ex_mem_reg_write = 0; ex_mem_dst = 0;
    #2;
    checks++;
    if (stall_b !== 1'b1 || stall_cycles !== 16'(base + (FWD ? 0 : 1))) begin
      errors++;
      $display("[TB] FAIL mem_dep_count: got %0d expected %0d", stall_cycles, base + (FWD ? 0 : 1));
    end
    tick();
    base = m_stalls;
    id_ex_reg_write = 1; id_ex_dst = 4;
    #2;
    checks++;
    if (stall_b !== FWD) begin
      errors++;
      $display("[TB] FAIL ex_dep_first: got %b expected %b", stall_b, FWD);
    end
    tick();
    id_ex_reg_write = 0; id_ex_dst = 0; ex_mem_reg_write = 1; ex_mem_dst = 4;
    #2;
    checks++;
    if (stall_b !== FWD) begin
      errors++;
      $display("[TB] FAIL ex_dep_second: got %b expected %b", stall_b, FWD);
    end
    tick();
    ex_mem_reg_write = 0; ex_mem_dst = 0;
    #2;
    checks++;
    if (stall_b !== 1'b1 || stall_cycles !== 16'(base + (FWD ? 0 : 2))) begin
      errors++;
      $display("[TB] FAIL ex_dep_count: got %0d expected %0d", stall_cycles, base + (FWD ? 0 : 2));
    end
    tick();
  endtask

  task automatic test_redirect_freeze();
    set_idle();
    pc_redirect = 1; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (if_id_flush !== 1'b0 || id_ex_flush !== 1'b0 || pipe_en !== 1'b0 || pc_write !== 1'b0) begin
        errors++;
        $display("[TB] FAIL freeze_%0d: got %b expected flushes=0 pipe_en=0", i, obs);
      end
      tick();
    end
    mem_busy = 0;
    #2;
    checks++;
    if (if_id_flush !== 1'b1 || id_ex_flush !== 1'b1 || pc_write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL redirect_after_freeze: got %b expected both flushes 1", obs);
    end
    tick();
    pc_redirect = 0;
    #2;
    checks++;
    if (if_id_flush !== 1'b0 || id_ex_flush !== 1'b0 || obs !== exp_out()) begin
      errors++;
      $display("[TB] FAIL redirect_single: got %b expected %b", obs, exp_out());
    end
    tick();
  endtask

  task automatic test_halt_drain();
    int edges;
    set_idle();
    if_id_instruction = {6'h3f, 26'd0};
    #2;
    checks++;
    if (stall_b !== 1'b0 || pc_write !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_detect: got %b expected stall_b=0 pc_write=0", obs);
    end
    tick();
    edges = 1;
    set_idle();
    while (edges < 20) begin
      mem_busy = (edges == 2 || edges == 3);
      #2;
      if (halted === 1'b1) break;
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("[TB] FAIL drain_edge_%0d: got %b expected %b", edges, obs, exp_out());
      end
      tick();
      edges++;
    end
    checks++;
    if (edges !== DRAIN + 3) begin
      errors++;
      $display("[TB] FAIL halt_latency: got %0d edges expected %0d", edges, DRAIN + 3);
    end
    mem_busy = 0; pc_redirect = 1;
    tick();
    #2;
    checks++;
    if (halted !== 1'b1 || pc_write !== 1'b0 || pipe_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halted_sticky: got %b expected 0000001", obs);
    end
    rst_b = 0;
    model_reset();
    #1;
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_reset: got %b expected 0", halted);
    end
    @(negedge clk);
    rst_b = 1;
    set_idle();
  endtask

  task automatic test_halt_redirect();
    set_idle();
    if_id_instruction = {6'h3f, 26'd0};
    #2;
    tick();
    set_idle();
    #2;
    checks++;
    if (obs !== exp_out()) begin
      errors++;
      $display("[TB] FAIL drain_entry: got %b expected %b", obs, exp_out());
    end
    tick();
    pc_redirect = 1;
    #2;
    checks++;
    if (if_id_flush !== 1'b1 || id_ex_flush !== 1'b1 || pc_write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drain_redirect: got %b expected flushes=1 pc_write=1", obs);
    end
    tick();
    pc_redirect = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      checks++;
      if (halted !== 1'b0 || obs !== exp_out()) begin
        errors++;
        $display("[TB] FAIL after_wrong_halt_%0d: got %b expected %b", i, obs, exp_out());
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    logic [5:0] op;
    ops = '{6'h00, 6'h04, 6'h2b, 6'h23, 6'h02, 6'h08, 6'h00, 6'h2b};
    for (int i = 0; i < 400; i++) begin
      rst_b = ($urandom_range(0, 29) != 0);
      if (!rst_b) model_reset();
      op = ($urandom_range(0, 19) == 0) ? 6'h3f : ops[$urandom_range(0, 7)];
      if_id_instruction = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      id_ex_mem_read   = ($urandom_range(0, 2) == 0);
      id_ex_reg_write  = id_ex_mem_read | ($urandom_range(0, 1) == 0);
      id_ex_dst        = 5'($urandom_range(0, 3));
      ex_mem_reg_write = ($urandom_range(0, 1) == 0);
      ex_mem_dst       = 5'($urandom_range(0, 3));
      pc_redirect      = ($urandom_range(0, 7) == 0);
      mem_busy         = ($urandom_range(0, 3) == 0);
      #2;
      checks++;
      if (obs !== exp_out() || stall_cycles !== 16'(m_stalls)) begin
        errors++;
        $display("[TB] FAIL random_%0d: got %b/%0d expected %b/%0d", i, obs, stall_cycles, exp_out(), m_stalls);
      end
      tick();
    end
    rst_b = 1;
    set_idle();
  endtask

  task automatic test_saturation();
    set_idle();
    id_ex_mem_read = 1; id_ex_reg_write = 1; id_ex_dst = 7;
    if_id_instruction = {6'h00, 5'd7, 5'd1, 5'd6, 5'd0, 6'h20};
    repeat (70000) tick();
    #2;
    checks++;
    if (stall_cycles !== 16'hFFFF || stall_cycles !== 16'(m_stalls) || stall_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL saturation: got %h expected ffff", stall_cycles);
    end
    @(posedge clk);
    #3;
    rst_b = 0;
    model_reset();
    #1;
    checks++;
    if (stall_cycles !== 16'd0 || obs !== 7'b0) begin
      errors++;
      $display("[TB] FAIL async_clear: got %h/%b expected 0000/0000000", stall_cycles, obs);
    end
    @(negedge clk);
    rst_b = 1;
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_dependency_stall();
    test_redirect_freeze();
    test_halt_drain();
    test_halt_redirect();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
